led_driver: RTL and testbench
=============================

# led_driver

Output stage between the LED register block and the board's LED pins. Takes the 16-bit pattern held by the LED register and drives the physical LEDs with CPU-programmable PWM brightness and an optional blink mode. A 16-bit control register is written by the CPU through its own memorio-decoded chip select. A prescaled tick generator, a PWM slot counter and a frame/blink sequencer run continuously.

## Interface
- PRESCALE, 16: `led_clk` cycles per PWM tick; legal range ≥1.
- led_clk  in  1  system clock; all state updates on its rising edge.
- ledrst  in  1  synchronous, active-high reset.
- ledin  in  16  LED pattern from the LED register block; bit i maps to `ledpin[i]`.
- ctrlcs  in  1  control-register chip select from memorio.
- ctrlwrite  in  1  write strobe; the write occurs when `ctrlcs && ctrlwrite`.
- ctrlwdata  in  16  control-register write data.
- ctrlrdata  out  16  current control-register contents.
- ledpin  out  16  registered drive to the board LEDs.

## Operation
- Control register fields:
  - [3:0] duty d.
  - [5:4] mode: 00 steady, 01 blink, 10 breathe, 11 treated as steady.
  - [7:6] stored, no effect.
  - [15:8] blink half-period P, in frames; P=0 behaves as P=1.
- Tick:
  - The prescale counter counts 0..PRESCALE-1 and wraps.
  - `tick` is asserted in the cycle where the count equals PRESCALE-1.
- PWM:
  - The 4-bit slot counter s increments on `tick` and wraps 15→0.
  - A frame is 16 ticks.
  - End-of-frame is the `tick` at which s=15.
- Effective duty e:
  - e = d in steady and blink modes.
  - e = ramp in breathe mode.
- pwm_on = (s <= e). Consequences:
  - d=0 gives 1/16 on-time.
  - d=15 gives always on.
- Blink:
  - The frame counter increments at each end-of-frame.
  - When it reaches max(P,1)−1 at an end-of-frame, it returns to 0 and phase toggles.
  - The LEDs are on only while phase=1.
- Breathe ramp (4-bit, up/down flag):
  - Steps once per end-of-frame in the sequence 0,1,…,15,14,…,1,0,1,….
  - Direction reverses at 15 and at 0.
- Output: ledpin ← ledin & {16{pwm_on && (mode≠blink || phase)}}.
- Any control write:
  - Loads the register.
  - Clears the frame counter.
  - Sets phase=1.
  - Sets ramp=0 with direction up.
  - Leaves the prescale and slot counters running undisturbed.
- ctrlrdata always returns the stored register, including reserved bits and mode 10 when breathe is compiled out.

## Timing
- Reset values (with `ledrst` sampled high):
  - ledpin=0.
  - Control register=16'h010F (d=15, steady, P=1).
  - Prescale, slot and frame counters=0.
  - phase=1, ramp=0, direction up.
- Reset priority: reset wins over a control write in the same cycle. Reset mid-blink or mid-breathe takes full effect at the next edge.
- Latency:
  - `ledin` change → `ledpin` one cycle later.
  - Control write → ctrlrdata updates at the next edge, and the new mode/duty affects `ledpin` one cycle after that.
- Write coinciding with a tick:
  - The write takes precedence for frame counter, phase and ramp.
  - The slot counter still advances.
- Counters wrap silently. No overflow flags exist.

## Configuration
- LED_BREATHE_EN defined: mode 10 selects breathe and the ramp logic is built.
- LED_BREATHE_EN undefined:
  - No ramp or direction registers are built.
  - Mode 10 behaves exactly as steady with e=d.
  - Register storage and readback are unchanged.

## Test plan
All scenarios use PRESCALE=2, so one frame is 32 clocks.
- Reset: hold `ledrst` for 2 cycles with ledin=16'hFFFF → ledpin=0 during reset; ledpin=16'hFFFF from the first edge after deassert; ctrlrdata=16'h010F.
- Duty: write 16'h0103 with ledin=16'h00FF → per 32-clock frame, ledpin=16'h00FF for 8 clocks (slots 0–3) and 0 for 24.
- Blink: write 16'h021F with ledin=16'hA5A5 → ledpin=16'hA5A5 for 64 clocks, then 0 for 64, repeating. Write 16'h001F → toggle every 32 clocks.
- Breathe, with LED_BREATHE_EN defined: write 16'h0020 → on-slots per frame 1,2,…,16,15,…,1,2.
- Breathe, without LED_BREATHE_EN: the same write 16'h0020 → 1 on-slot per frame (d=0); ctrlrdata=16'h0020.
- Collision: during the blink off phase, assert `ledrst` in the same cycle as a write of 16'h0003 → next cycle ledpin=0 and ctrlrdata=16'h010F.
- Restart: a write during the blink off phase → phase=1 and the LEDs on within 2 cycles; the slot counter is not reset.

Source files
------------

// File: rtl/led_driver.sv
// led_driver: PWM / blink / breathe output stage for the 16 board LEDs.
// A prescaled tick drives a 4-bit PWM slot counter. Sixteen ticks make one
// frame. The end of each frame steps the blink frame counter and the breathe
// ramp. The optional breathe mode (control mode 10) is built only when the
// macro LED_BREATHE_EN is defined. Otherwise mode 10 acts as steady.
module led_driver #(
   parameter int PRESCALE = 16
) (
   input  logic        led_clk,
   input  logic        ledrst,
   input  logic [15:0] ledin,
   input  logic        ctrlcs,
   input  logic        ctrlwrite,
   input  logic [15:0] ctrlwdata,
   output logic [15:0] ctrlrdata,
   output logic [15:0] ledpin
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [15:0] CTRL_RESET = 16'h010F;

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    slot_q, slot_d;
   logic [7:0]    frame_q, frame_d;
   logic          phase_q, phase_d;
   logic [15:0]   ctrl_q, ctrl_d;
   logic [15:0]   ledpin_q, ledpin_d;
`ifdef LED_BREATHE_EN
   logic [3:0]    ramp_q, ramp_d;
   logic          dir_down_q, dir_down_d;
`endif

   logic          tick;
   logic          eof;
   logic          ctrl_wr;
   logic [7:0]    frame_last;
   logic [3:0]    eff_duty;
   logic          pwm_on;
   logic          blink_mode;

   // Next-state logic for the tick, slot, blink and ramp sequencers, and for the LED drive.
   always_comb begin
      tick       = (presc_q == PRESC_MAX);
      eof        = tick && (slot_q == 4'hF);
      ctrl_wr    = ctrlcs && ctrlwrite;
      // P=0 is treated as P=1, so the last frame index is 0 in both cases.
      frame_last = (ctrl_q[15:8] == 8'd0) ? 8'd0 : (ctrl_q[15:8] - 8'd1);
      blink_mode = (ctrl_q[5:4] == 2'b01);

      // The prescaler and slot counter always run, even across control writes.
      presc_d = tick ? '0 : (presc_q + PW'(1));
      slot_d  = tick ? (slot_q + 4'd1) : slot_q;

      ctrl_d  = ctrl_q;
      frame_d = frame_q;
      phase_d = phase_q;
      if (ctrl_wr) begin
         ctrl_d  = ctrlwdata;
         frame_d = 8'd0;
         phase_d = 1'b1;
      end else if (eof) begin
         if (frame_q == frame_last) begin
            frame_d = 8'd0;
            phase_d = ~phase_q;
         end else begin
            frame_d = frame_q + 8'd1;
         end
      end

      eff_duty = ctrl_q[3:0];
`ifdef LED_BREATHE_EN
      // The triangle ramp turns around at 15 and at 0 and steps once per frame.
      ramp_d     = ramp_q;
      dir_down_d = dir_down_q;
      if (ctrl_wr) begin
         ramp_d     = 4'd0;
         dir_down_d = 1'b0;
      end else if (eof) begin
         if (!dir_down_q) begin
            if (ramp_q == 4'hF) begin
               ramp_d     = 4'hE;
               dir_down_d = 1'b1;
            end else begin
               ramp_d = ramp_q + 4'd1;
            end
         end else begin
            if (ramp_q == 4'h0) begin
               ramp_d     = 4'h1;
               dir_down_d = 1'b0;
            end else begin
               ramp_d = ramp_q - 4'd1;
            end
         end
      end
      if (ctrl_q[5:4] == 2'b10) begin
         eff_duty = ramp_q;
      end
`endif

      // Slot 0 is always lit, so duty 0 still gives 1/16 on-time.
      pwm_on   = (slot_q <= eff_duty);
      ledpin_d = ledin & {16{pwm_on && (!blink_mode || phase_q)}};
   end

   // All state registers. Reset has priority over a control write.
   always_ff @(posedge led_clk) begin
      if (ledrst) begin
         presc_q    <= '0;
         slot_q     <= 4'd0;
         frame_q    <= 8'd0;
         phase_q    <= 1'b1;
         ctrl_q     <= CTRL_RESET;
         ledpin_q   <= 16'h0000;
`ifdef LED_BREATHE_EN
         ramp_q     <= 4'd0;
         dir_down_q <= 1'b0;
`endif
      end else begin
         presc_q    <= presc_d;
         slot_q     <= slot_d;
         frame_q    <= frame_d;
         phase_q    <= phase_d;
         ctrl_q     <= ctrl_d;
         ledpin_q   <= ledpin_d;
`ifdef LED_BREATHE_EN
         ramp_q     <= ramp_d;
         dir_down_q <= dir_down_d;
`endif
      end
   end

   assign ctrlrdata = ctrl_q;
   assign ledpin    = ledpin_q;

endmodule

// File: tb/tb_led_driver.sv
// Testbench for led_driver with PRESCALE=2, so one frame is 32 clocks.
// The reference model tracks the elapsed cycle count and the number of
// end-of-frame events since the last control write. It derives the slot,
// the blink phase and the breathe ramp from those counts by plain arithmetic.
module tb_led_driver;

   localparam int PS = 2;

   logic        led_clk = 1'b0;
   logic        ledrst;
   logic [15:0] ledin;
   logic        ctrlcs;
   logic        ctrlwrite;
   logic [15:0] ctrlwdata;
   logic [15:0] ctrlrdata;
   logic [15:0] ledpin;

   int total = 0;
   int bad   = 0;

   // model state
   int          m_n;      // cycles since reset released
   int          m_eofs;   // end-of-frame events since last write/reset
   logic [15:0] m_ctrl;

   led_driver #(.PRESCALE(PS)) dut (
      .led_clk   (led_clk),
      .ledrst    (ledrst),
      .ledin     (ledin),
      .ctrlcs    (ctrlcs),
      .ctrlwrite (ctrlwrite),
      .ctrlwdata (ctrlwdata),
      .ctrlrdata (ctrlrdata),
      .ledpin    (ledpin)
   );

   always #5 led_clk = ~led_clk;

`ifdef LED_BREATHE_EN
   function automatic int ramp_of(input int eofs);
      int r;
      r = eofs % 30;
      return (r <= 15) ? r : (30 - r);
   endfunction
`endif

   function automatic bit model_phase();
      int peff;
      peff = (m_ctrl[15:8] == 8'd0) ? 1 : int'(m_ctrl[15:8]);
      return ((m_eofs / peff) % 2) == 0;
   endfunction

   // Advance one clock: predict the DUT outputs after the edge, update the model,
   // then move to 1 time unit after the edge.
   task automatic clk_step(output logic [15:0] ep, output logic [15:0] er);
      int slot;
      int e;
      bit on;
      if (ledrst) begin
         ep = 16'h0000;
      end else begin
         slot = (m_n / PS) % 16;
         e    = int'(m_ctrl[3:0]);
`ifdef LED_BREATHE_EN
         if (m_ctrl[5:4] == 2'b10) e = ramp_of(m_eofs);
`endif
         on = (slot <= e) && ((m_ctrl[5:4] != 2'b01) || model_phase());
         ep = on ? ledin : 16'h0000;
      end
      if (ledrst) begin
         m_n    = 0;
         m_eofs = 0;
         m_ctrl = 16'h010F;
      end else begin
         if (ctrlcs && ctrlwrite) begin
            m_ctrl = ctrlwdata;
            m_eofs = 0;
         end else if ((m_n % (16 * PS)) == (16 * PS - 1)) begin
            m_eofs = m_eofs + 1;
         end
         m_n = m_n + 1;
      end
      er = m_ctrl;
      @(posedge led_clk);
      #1;
   endtask

   task automatic do_write(input logic [15:0] data);
      logic [15:0] ep, er;
      ctrlcs = 1'b1; ctrlwrite = 1'b1; ctrlwdata = data;
      clk_step(ep, er);
      ctrlcs = 1'b0; ctrlwrite = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] ep, er;
      ledin = 16'hFFFF; ledrst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         clk_step(ep, er);
         total++;
         if (ledpin !== 16'h0000) begin bad++; $display("FAIL reset_ledpin cyc=%0d got=%h want=0000", i, ledpin); end
         total++;
         if (ctrlrdata !== 16'h010F) begin bad++; $display("FAIL reset_ctrl got=%h want=010F", ctrlrdata); end
      end
      ledrst = 1'b0;
      clk_step(ep, er);
      total++;
      if (ledpin !== 16'hFFFF) begin bad++; $display("FAIL reset_first got=%h want=FFFF", ledpin); end
      for (int i = 0; i < 40; i++) begin
         clk_step(ep, er);
         total++;
         if (ledpin !== ep || ctrlrdata !== er) begin
            bad++; $display("FAIL reset_run cyc=%0d pin=%h want=%h rd=%h want=%h", i, ledpin, ep, ctrlrdata, er);
         end
      end
      $display("test_reset checked");
   endtask

   task automatic test_duty();
      logic [15:0] ep, er;
      int on_cnt = 0;
      ledin = 16'h00FF;
      // align the write so the next cycle starts a frame
      while ((m_n % (16 * PS)) != (16 * PS - 1)) clk_step(ep, er);
      do_write(16'h0103);
      clk_step(ep, er);  // ctrl just loaded, ledpin still from old duty
      for (int i = 0; i < 64; i++) begin
         clk_step(ep, er);
         if (i >= 32 && ledpin == 16'h00FF) on_cnt++;
         total++;
         if (ledpin !== ep || ctrlrdata !== 16'h0103) begin
            bad++; $display("FAIL duty cyc=%0d pin=%h want=%h rd=%h", i, ledpin, ep, ctrlrdata);
         end
      end
      total++;
      if (on_cnt != 8) begin bad++; $display("FAIL duty_on_count got=%0d want=8", on_cnt); end
      $display("test_duty checked");
   endtask

   task automatic test_blink();
      logic [15:0] ep, er;
      ledin = 16'hA5A5;
      do_write(16'h021F);
      for (int i = 0; i < 300; i++) begin
         clk_step(ep, er);
         total++;
         if (ledpin !== ep || ctrlrdata !== er) begin
            bad++; $display("FAIL blink_p2 cyc=%0d pin=%h want=%h rd=%h want=%h", i, ledpin, ep, ctrlrdata, er);
         end
      end
      do_write(16'h001F);
      for (int i = 0; i < 150; i++) begin
         clk_step(ep, er);
         total++;
         if (ledpin !== ep || ctrlrdata !== er) begin
            bad++; $display("FAIL blink_p0 cyc=%0d pin=%h want=%h rd=%h want=%h", i, ledpin, ep, ctrlrdata, er);
         end
      end
      $display("test_blink checked");
   endtask

   task automatic test_breathe();
      logic [15:0] ep, er;
      ledin = 16'hFFFF;
      do_write(16'h0020);
      for (int i = 0; i < 34 * 32; i++) begin
         clk_step(ep, er);
         total++;
         if (ledpin !== ep || ctrlrdata !== 16'h0020) begin
            bad++; $display("FAIL breathe cyc=%0d pin=%h want=%h rd=%h", i, ledpin, ep, ctrlrdata);
         end
      end
      $display("test_breathe checked");
   endtask

   task automatic test_collision();
      logic [15:0] ep, er;
      int guard = 0;
      ledin = 16'hA5A5;
      do_write(16'h021F);
      while (model_phase() && guard < 400) begin clk_step(ep, er); guard++; end
      total++;
      if (guard >= 400) begin bad++; $display("FAIL collision_timeout guard=%0d", guard); end
      clk_step(ep, er);
      total++;
      if (ledpin !== 16'h0000) begin bad++; $display("FAIL collision_off pin=%h want=0000", ledpin); end
      ledrst = 1'b1; ctrlcs = 1'b1; ctrlwrite = 1'b1; ctrlwdata = 16'h0003;
      clk_step(ep, er);
      ledrst = 1'b0; ctrlcs = 1'b0; ctrlwrite = 1'b0;
      total++;
      if (ledpin !== 16'h0000) begin bad++; $display("FAIL collision_pin got=%h want=0000", ledpin); end
      total++;
      if (ctrlrdata !== 16'h010F) begin bad++; $display("FAIL collision_ctrl got=%h want=010F", ctrlrdata); end
      for (int i = 0; i < 40; i++) begin
         clk_step(ep, er);
         total++;
         if (ledpin !== ep || ctrlrdata !== er) begin
            bad++; $display("FAIL collision_run cyc=%0d pin=%h want=%h", i, ledpin, ep);
         end
      end
      $display("test_collision checked");
   endtask

   task automatic test_restart();
      logic [15:0] ep, er;
      int guard = 0;
      ledin = 16'h5AC3;
      do_write(16'h021F);
      while (model_phase() && guard < 400) begin clk_step(ep, er); guard++; end
      total++;
      if (guard >= 400) begin bad++; $display("FAIL restart_timeout guard=%0d", guard); end
      for (int i = 0; i < 3; i++) clk_step(ep, er);
      total++;
      if (ledpin !== 16'h0000) begin bad++; $display("FAIL restart_off pin=%h want=0000", ledpin); end
      do_write(16'h021F);
      clk_step(ep, er);
      total++;
      if (ledpin !== 16'h5AC3) begin bad++; $display("FAIL restart_on got=%h want=5AC3", ledpin); end
      for (int i = 0; i < 100; i++) begin
         clk_step(ep, er);
         total++;
         if (ledpin !== ep || ctrlrdata !== er) begin
            bad++; $display("FAIL restart_run cyc=%0d pin=%h want=%h", i, ledpin, ep);
         end
      end
      $display("test_restart checked");
   endtask

   task automatic test_random();
      logic [15:0] ep, er;
      for (int i = 0; i < 3000; i++) begin
         ledin     = 16'($urandom);
         ledrst    = ($urandom_range(0, 799) == 0);
         ctrlcs    = ($urandom_range(0, 3) != 0);
         ctrlwrite = ($urandom_range(0, 79) == 0);
         ctrlwdata = {8'($urandom_range(0, 3)), 8'($urandom)};
         clk_step(ep, er);
         total++;
         if (ledpin !== ep || ctrlrdata !== er) begin
            bad++; $display("FAIL random cyc=%0d pin=%h want=%h rd=%h want=%h", i, ledpin, ep, ctrlrdata, er);
         end
      end
      ledrst = 1'b0; ctrlcs = 1'b0; ctrlwrite = 1'b0;
      $display("test_random checked");
   endtask

   initial begin
      ledrst = 1'b1; ledin = 16'h0000; ctrlcs = 1'b0; ctrlwrite = 1'b0; ctrlwdata = 16'h0000;
      m_n = 0; m_eofs = 0; m_ctrl = 16'h010F;
      test_reset();
      test_duty();
      test_blink();
      test_breathe();
      test_collision();
      test_restart();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
